// File: rtl/present_inv_sbox_serial_d1.sv
// Two-share masked PRESENT inverse S-box layer, nibble-serial.
// Each nibble passes a GHPC-style masked core of one or two register-separated stages.
module present_inv_sbox_serial_d1 #(
   parameter int low_latency = 0,
   parameter int pipeline    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] in0,
   input  logic [63:0] in1,
   input  logic [7:0]  r,
   output logic        busy,
   output logic        done,
   output logic [63:0] out0,
   output logic [63:0] out1
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Affine constant of the inverse S-box; added to share 0 only.
   localparam logic [3:0] AFF_C = 4'h5;

   // Inverse S-box with its affine constant removed: sinv_core(x) = Sinv(x) ^ 5.
   function automatic logic [3:0] sinv_core(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0:    y = 4'h0;
         4'h1:    y = 4'hB;
         4'h2:    y = 4'hA;
         4'h3:    y = 4'hD;
         4'h4:    y = 4'h9;
         4'h5:    y = 4'h4;
         4'h6:    y = 4'h7;
         4'h7:    y = 4'h8;
         4'h8:    y = 4'hE;
         4'h9:    y = 4'h1;
         4'hA:    y = 4'h3;
         4'hB:    y = 4'h6;
         4'hC:    y = 4'h5;
         4'hD:    y = 4'h2;
         4'hE:    y = 4'hC;
         4'hF:    y = 4'hF;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   // GHPC table: entry j = core(x0 ^ j) ^ m; depends on share 0 and randomness only.
   function automatic logic [63:0] ghpc_table(input logic [3:0] x0, input logic [3:0] m);
      logic [63:0] t;
      logic [3:0]  jn;
      t = 64'h0;
      for (int j = 0; j < 16; j++) begin
         jn = j[3:0];
         t[4*j +: 4] = sinv_core(x0 ^ jn) ^ m;
      end
      return t;
   endfunction

   function automatic logic [3:0] tab_sel(input logic [63:0] t, input logic [3:0] sel);
      return t[{sel, 2'b00} +: 4];
   endfunction

   logic [1:0]  state_r;
   logic        busy_r;
   logic        done_r;
   logic [63:0] st0_r;
   logic [63:0] st1_r;
   logic [3:0]  issue_cnt_r;
   logic        all_issued_r;
   logic [63:0] out0_r;
   logic [63:0] out1_r;

   logic        s1_v_r;
   logic [3:0]  s1_idx_r;
   logic [63:0] s1_tab_r;
   logic [3:0]  s1_x1_r;
   logic [3:0]  s1_m_r;

   logic        issue_s;
   logic        stall_s;
   logic        last_collect_s;
   logic [3:0]  iss_x0_s;
   logic [3:0]  iss_x1_s;
   logic [3:0]  s1_rnd_s;
   logic        fin_v_s;
   logic [3:0]  fin_idx_s;
   logic [3:0]  fin_y0_s;
   logic [3:0]  fin_y1_s;

   // Issue decision and selection of the nibble shares to issue.
   always_comb begin
      iss_x0_s = st0_r[{issue_cnt_r, 2'b00} +: 4];
      iss_x1_s = st1_r[{issue_cnt_r, 2'b00} +: 4];
      issue_s  = 1'b0;
      if ((state_r == ST_RUN) && !all_issued_r && ((pipeline != 0) || !stall_s)) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
      last_collect_s = fin_v_s && (fin_idx_s == 4'hF);
   end

   // Control FSM with state capture on an accepted start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         st0_r   <= 64'h0;
         st1_r   <= 64'h0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  st0_r   <= in0;
                  st1_r   <= in1;
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (last_collect_s) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Issue counter; saturates after nibble 15 instead of wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         issue_cnt_r  <= 4'h0;
         all_issued_r <= 1'b0;
      end else if ((state_r == ST_IDLE) && start) begin
         issue_cnt_r  <= 4'h0;
         all_issued_r <= 1'b0;
      end else if (issue_s) begin
         if (issue_cnt_r == 4'hF) begin
            all_issued_r <= 1'b1;
         end else begin
            issue_cnt_r <= issue_cnt_r + 4'd1;
         end
      end
   end

   // Core stage 1: register the share-0 table, share 1 and the output mask.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v_r   <= 1'b0;
         s1_idx_r <= 4'h0;
         s1_tab_r <= 64'h0;
         s1_x1_r  <= 4'h0;
         s1_m_r   <= 4'h0;
      end else begin
         s1_v_r <= issue_s;
         if (issue_s) begin
            s1_idx_r <= issue_cnt_r;
            s1_tab_r <= ghpc_table(iss_x0_s, s1_rnd_s);
            s1_x1_r  <= iss_x1_s;
            s1_m_r   <= s1_rnd_s;
         end
      end
   end

   generate
      if (low_latency != 0) begin : g_l1
         assign s1_rnd_s = r[3:0] ^ r[7:4];
         assign stall_s  = 1'b0;

         // Single stage: share 1 selects its table entry straight after the register.
         always_comb begin
            fin_v_s   = s1_v_r;
            fin_idx_s = s1_idx_r;
            fin_y0_s  = tab_sel(s1_tab_r, s1_x1_r) ^ AFF_C;
            fin_y1_s  = s1_m_r;
         end
      end else begin : g_l2
         logic       s2_v_r;
         logic [3:0] s2_idx_r;
         logic [3:0] s2_y0_r;
         logic [3:0] s2_y1_r;

         assign s1_rnd_s = r[3:0];
         assign stall_s  = s1_v_r;

         // Core stage 2: resolve the table and refresh both shares with r[7:4].
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               s2_v_r   <= 1'b0;
               s2_idx_r <= 4'h0;
               s2_y0_r  <= 4'h0;
               s2_y1_r  <= 4'h0;
            end else begin
               s2_v_r <= s1_v_r;
               if (s1_v_r) begin
                  s2_idx_r <= s1_idx_r;
                  s2_y0_r  <= tab_sel(s1_tab_r, s1_x1_r) ^ r[7:4] ^ AFF_C;
                  s2_y1_r  <= s1_m_r ^ r[7:4];
               end
            end
         end

         // Final-stage view of the two-stage core.
         always_comb begin
            fin_v_s   = s2_v_r;
            fin_idx_s = s2_idx_r;
            fin_y0_s  = s2_y0_r;
            fin_y1_s  = s2_y1_r;
         end
      end
   endgenerate

   // Collect: write only the nibble field carried with the valid result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out0_r <= 64'h0;
         out1_r <= 64'h0;
      end else if (fin_v_s) begin
         out0_r[{fin_idx_s, 2'b00} +: 4] <= fin_y0_s;
         out1_r[{fin_idx_s, 2'b00} +: 4] <= fin_y1_s;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign out0 = out0_r;
   assign out1 = out1_r;

endmodule

// File: tb/tb_present_inv_sbox_serial_d1.sv
// Bench for the masked inverse S-box layer: three parameter sets share one stimulus
// stream and are checked every cycle against a latency/result model.
module tb_present_inv_sbox_serial_d1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start;
   logic [63:0] in0;
   logic [63:0] in1;
   logic [7:0]  r;
   logic        r_zero;
   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   logic [2:0][63:0] o0_v;
   logic [2:0][63:0] o1_v;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   // Latency from accept edge to done cycle: pipelined 16+L, otherwise 16*L+1.
   int          lat [3] = '{18, 33, 17};
   bit          m_act [3];
   int          m_k [3];
   logic [63:0] m_exp [3];

   logic [3:0] sinv_tab [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                 4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

   present_inv_sbox_serial_d1 #(.low_latency(0), .pipeline(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .in0(in0), .in1(in1), .r(r),
      .busy(busy_v[0]), .done(done_v[0]), .out0(o0_v[0]), .out1(o1_v[0]));
   present_inv_sbox_serial_d1 #(.low_latency(0), .pipeline(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .in0(in0), .in1(in1), .r(r),
      .busy(busy_v[1]), .done(done_v[1]), .out0(o0_v[1]), .out1(o1_v[1]));
   present_inv_sbox_serial_d1 #(.low_latency(1), .pipeline(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .in0(in0), .in1(in1), .r(r),
      .busy(busy_v[2]), .done(done_v[2]), .out0(o0_v[2]), .out1(o1_v[2]));

   function automatic logic [63:0] inv_layer(input logic [63:0] s);
      logic [63:0] res;
      for (int i = 0; i < 16; i++) res[4*i +: 4] = sinv_tab[s[4*i +: 4]];
      return res;
   endfunction

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) r = r_zero ? 8'h00 : 8'($urandom);

   // Reference model: tracks accept edge, expected result and activity per instance.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) begin
            m_act[d] = 1'b0;
         end else if (m_act[d]) begin
            if (cyc - m_k[d] == lat[d]) m_act[d] = 1'b0;
         end else if (start) begin
            m_act[d] = 1'b1;
            m_k[d]   = cyc + 1;
            m_exp[d] = inv_layer(in0 ^ in1);
         end
      end
      cyc = cyc + 1;
   end

   // Compare process: busy/done every cycle, recombined result on done.
   always @(negedge clk) begin
      bit eb;
      bit ed;
      if (chk_en) begin
         for (int d = 0; d < 3; d++) begin
            eb = 1'b0;
            ed = 1'b0;
            if (m_act[d]) begin
               eb = (cyc - m_k[d]) < lat[d];
               ed = (cyc - m_k[d]) == lat[d];
            end
            check1($sformatf("busy[%0d]", d), busy_v[d], eb);
            check1($sformatf("done[%0d]", d), done_v[d], ed);
            if (ed) check64($sformatf("result[%0d]", d), o0_v[d] ^ o1_v[d], m_exp[d]);
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while ((m_act[0] || m_act[1] || m_act[2]) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: still active after %0d cycles, required idle", n);
      end
   endtask

   task automatic apply_start(input logic [63:0] s, input logic [63:0] m);
      @(negedge clk);
      in0   = s ^ m;
      in1   = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in0   = {$urandom, $urandom};
      in1   = {$urandom, $urandom};
   endtask

   task automatic run_op(input logic [63:0] s, input logic [63:0] m);
      apply_start(s, m);
      wait_idle();
   endtask

   task automatic check_all(input string name, input logic [63:0] exp);
      for (int d = 0; d < 3; d++)
         check64($sformatf("%s[%0d]", name, d), o0_v[d] ^ o1_v[d], exp);
   endtask

   initial begin
      logic [63:0] m;
      logic [63:0] first_o1;
      logic        differs;
      rst_n  = 1'b0;
      start  = 1'b0;
      in0    = 64'h0;
      in1    = 64'h0;
      r_zero = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      for (int d = 0; d < 3; d++) begin
         check1($sformatf("rst_busy[%0d]", d), busy_v[d], 1'b0);
         check1($sformatf("rst_done[%0d]", d), done_v[d], 1'b0);
         check64($sformatf("rst_out0[%0d]", d), o0_v[d], 64'h0);
         check64($sformatf("rst_out1[%0d]", d), o1_v[d], 64'h0);
      end

      run_op(64'h0, {$urandom, $urandom});
      check_all("zero_state", 64'h5555555555555555);

      m = {$urandom, $urandom};
      run_op(64'h0123456789ABCDEF, m);
      check_all("vector", 64'h5EF8C12DB463079A);

      // Starts during RUN must be ignored.
      apply_start(64'h0123456789ABCDEF, {$urandom, $urandom});
      repeat (2) @(negedge clk);
      in0 = 64'hFFFFFFFF00000000; in1 = 64'h0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (6) @(negedge clk);
      in0 = 64'h1111111111111111; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_idle();
      check_all("ignored_start", 64'h5EF8C12DB463079A);

      // Reset in the middle of RUN discards everything.
      apply_start(64'h0123456789ABCDEF, {$urandom, $urandom});
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int d = 0; d < 3; d++) begin
         check64($sformatf("midrst_out0[%0d]", d), o0_v[d], 64'h0);
         check64($sformatf("midrst_out1[%0d]", d), o1_v[d], 64'h0);
      end
      run_op(64'hFFFFFFFFFFFFFFFF, {$urandom, $urandom});
      check_all("all_ones", 64'hAAAAAAAAAAAAAAAA);

      r_zero = 1'b1;
      run_op({$urandom, $urandom}, {$urandom, $urandom});
      r_zero = 1'b0;

      // Same unmasked input, fresh masks: share 1 must vary.
      differs  = 1'b0;
      first_o1 = 64'h0;
      for (int i = 0; i < 8; i++) begin
         run_op(64'h0123456789ABCDEF, {$urandom, $urandom});
         if (i == 0) first_o1 = o1_v[0];
         else if (o1_v[0] != first_o1) differs = 1'b1;
      end
      check1("out1_varies", differs, 1'b1);

      for (int i = 0; i < 1000; i++)
         run_op({$urandom, $urandom}, {$urandom, $urandom});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/present_inv_sbox_serial_d1.md
Name: present_inv_sbox_serial_d1

Overview:
- First-order (2-share) masked PRESENT inverse S-box layer for nibble-serial PRESENT-80 decryption.
- Mirrors the encryption-side masked S-box path. It loads a shared 64-bit state, streams its 16 nibbles through a GHPC-style masked inverse S-box pipeline, and collects the results into a shared 64-bit output register.
- Sits between the inverse pLayer and the key-addition step in the decryption datapath, driven by the round controller through a start/done handshake.

Parameters:
- low_latency, 0, 0: masked core latency L=2 cycles (two gadget stages); 1: L=1 cycle.
- pipeline, 0, 1: a new nibble is issued every cycle (issue period P=1); 0: one nibble in flight at a time (P=L).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request to process the state on in0/in1; sampled only in IDLE.
- in0  input  64  state share 0; nibble i is bits 4i+3:4i.
- in1  input  64  state share 1.
- r  input  8  fresh randomness, consumed every cycle while busy (4 bits per gadget stage).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse; out0/out1 complete.
- out0  output  64  result share 0, registered.
- out1  output  64  result share 1, registered.

Behaviour:
- Reset (rst_n=0 at an edge): FSM to IDLE; busy=0, done=0, out0=out1=0; issue/collect counters and in-flight valid bits cleared. This applies mid-operation too: partial results are discarded.
- States:
  - IDLE: start=1 latches in0/in1 into the share state registers and goes to RUN.
  - RUN: issues nibbles and collects results.
  - DONE: asserts done for one cycle, then returns to IDLE.
- Issue: nibble i (i=0..15, LSB nibble first) enters the core at edge k+1+i·P, where k is the start-accept edge. A 4-bit issue counter stops after 15 with no wrap. pipeline=0 holds the next issue until the previous result is collected.
- Collect: the result of nibble i is written into out0/out1 bits 4i+3:4i at edge issue+L. A valid bit travels with each nibble through the L stages, and only the nibble field carried with it is written.
- done is high in the cycle after the 16th write.
  - pipeline=1: done at cycle k+16+L.
  - pipeline=0: done at cycle k+16·L+1.
- busy falls together with done rising.
- Core: out0^out1 = Sinv(in0^in1), with Sinv = 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A for x=0..F.
  - Shares are never combined in one non-linear term.
  - Each gadget stage is register-separated per GHPC.
  - Randomness is used once: r[3:0] goes to stage 1 and r[7:4] to stage 2 (both to the single stage when L=1).
  - Constant additions of the inverse affine layer are applied to share 0 only.
- start while busy or in DONE is ignored. in0/in1 may change after acceptance without effect.
- out0/out1 hold their value after done until the next accepted start. They update nibble-wise during RUN, so consumers use them only on done.
- With r held at 0 the functional result is unchanged; only masking security is lost.

Test Plan:
- Reset, then in0=in1=0, start=1 for one cycle, random r -> done after the specified latency; out0^out1=0x5555555555555555; busy=0 after done.
- in0=0x0123456789ABCDEF^M, in1=M (M random), pipeline=1, low_latency=0 -> done exactly 18 cycles after the accept edge; out0^out1=0x5EF8C12DB463079A.
- Same vector with pipeline=0, low_latency=0 -> done at cycle 33 after accept; same XOR result. With low_latency=1, pipeline=1 -> done at cycle 17.
- Pulse start again at cycles 3 and 10 of RUN with a different state -> ignored; result equals the first state's inverse; exactly one done pulse.
- Assert rst_n=0 at cycle 8 of RUN -> next cycle busy=0, out0=out1=0, no done. A subsequent start with 0xFFFFFFFFFFFFFFFF -> out0^out1=0xAAAAAAAAAAAAAAAA.
- 1000 random states, masks and r streams against a golden inverse S-box -> all XOR results match, and out1 alone is not constant across runs with equal unmasked input.
